// File: rtl/dmem_axi_bridge.sv
// AXI4-Lite slave bridging the core's host data port to a word-wide memory strobe.
// Storage is either external (bench-supplied words) or an internal word array.
module dmem_axi_bridge #(
  parameter int RISCOF_TEST_MODE = 1,
  parameter int INT_DMEM_SIZE    = 1,
  parameter int AXI_AWIDTH       = 32,
  parameter int AXI_DWIDTH       = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  input  logic [AXI_DWIDTH-1:0]   DMEM_RDATA,
  input  logic [AXI_DWIDTH-1:0]   DMEM_WDATA_READ,
  output logic [AXI_DWIDTH-1:0]   DMEM_WDATA,
  output logic                    DMEM_WVALID
);

  localparam int SW = AXI_DWIDTH / 8;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [AXI_DWIDTH-1:0] old_word;
  logic [AXI_DWIDTH-1:0] rd_word;

  // Reset gates the accept so no write strobe escapes while the bridge is held.
  assign wr_accept   = AXI_ARESETN & AXI_AWVALID & AXI_WVALID & ~AXI_BVALID;
  assign AXI_AWREADY = wr_accept;
  assign AXI_WREADY  = wr_accept;
  assign DMEM_WVALID = wr_accept;
  assign AXI_ARREADY = ~AXI_RVALID;
  assign rd_accept   = AXI_ARVALID & AXI_ARREADY;
  assign AXI_BRESP   = '0;
  assign AXI_RRESP   = '0;

  always_comb begin
    DMEM_WDATA = old_word;
    for (int unsigned i = 0; i < SW; i++) begin
      if (AXI_WSTRB[i]) DMEM_WDATA[8*i +: 8] = AXI_WDATA[8*i +: 8];
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      AXI_BVALID <= 1'b0;
    end else if (AXI_BVALID && AXI_BREADY) begin
      AXI_BVALID <= 1'b0;
    end else if (wr_accept) begin
      AXI_BVALID <= 1'b1;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      AXI_RVALID <= 1'b0;
      AXI_RDATA  <= '0;
    end else if (rd_accept) begin
      AXI_RVALID <= 1'b1;
      AXI_RDATA  <= rd_word;
    end else if (AXI_RVALID && AXI_RREADY) begin
      AXI_RVALID <= 1'b0;
    end
  end

  if (RISCOF_TEST_MODE != 0) begin : g_ext
    assign old_word = DMEM_WDATA_READ;
    assign rd_word  = DMEM_RDATA;

    logic unused_addr;
    assign unused_addr = ^{AXI_AWADDR, AXI_ARADDR};
  end else begin : g_int
    localparam int IW = (INT_DMEM_SIZE > 1) ? $clog2(INT_DMEM_SIZE) : 1;

    logic [AXI_DWIDTH-1:0] mem [INT_DMEM_SIZE];
    logic [IW-1:0]         widx;
    logic [IW-1:0]         ridx;

    // Upper address bits are dropped so accesses wrap onto the array.
    assign widx     = (INT_DMEM_SIZE > 1) ? AXI_AWADDR[IW+1:2] : '0;
    assign ridx     = (INT_DMEM_SIZE > 1) ? AXI_ARADDR[IW+1:2] : '0;
    assign old_word = mem[widx];
    assign rd_word  = mem[ridx];

    always_ff @(posedge AXI_ACLK) begin
      if (wr_accept) mem[widx] <= DMEM_WDATA;
    end

    logic unused_dmem;
    assign unused_dmem = ^{DMEM_RDATA, DMEM_WDATA_READ, AXI_AWADDR, AXI_ARADDR};
  end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: external-memory instance plus a 4-word
// internal-array instance driven by the same AXI stimulus.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] awaddr, wdata, araddr, dmem_rdata, dmem_wdata_read;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid, dmem_wvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, dmem_wdata;

  logic        i_awready, i_wready, i_bvalid, i_arready, i_rvalid, i_dmem_wvalid;
  logic [1:0]  i_bresp, i_rresp;
  logic [31:0] i_rdata, i_dmem_wdata;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  dmem_axi_bridge #(.RISCOF_TEST_MODE(1), .INT_DMEM_SIZE(1)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rstn),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
    .DMEM_RDATA(dmem_rdata), .DMEM_WDATA_READ(dmem_wdata_read),
    .DMEM_WDATA(dmem_wdata), .DMEM_WVALID(dmem_wvalid)
  );

  dmem_axi_bridge #(.RISCOF_TEST_MODE(0), .INT_DMEM_SIZE(4)) dut_int (
    .AXI_ACLK(clk), .AXI_ARESETN(rstn),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(i_awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(i_wready),
    .AXI_BRESP(i_bresp), .AXI_BVALID(i_bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(i_arready),
    .AXI_RDATA(i_rdata), .AXI_RRESP(i_rresp), .AXI_RVALID(i_rvalid), .AXI_RREADY(rready),
    .DMEM_RDATA(dmem_rdata), .DMEM_WDATA_READ(dmem_wdata_read),
    .DMEM_WDATA(i_dmem_wdata), .DMEM_WVALID(i_dmem_wvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    awaddr = 32'h10; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    araddr = 32'h0; bready = 1'b0; rready = 1'b0;
    dmem_rdata = 32'h5A5A_5A5A; dmem_wdata_read = 32'h0;

    // Reset with valids asserted
    for (int i = 0; i < 2; i++) begin
      step();
      sample();
      check("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_wvalid", {31'b0, dmem_wvalid}, 32'd0);
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_bresp", {30'b0, bresp}, 32'd0);
    end
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rstn = 1'b1;
    step();

    // Only one of AW/W valid: nothing accepted
    awvalid = 1'b1;
    sample();
    check("aw_only_ready", {31'b0, awready}, 32'd0);
    check("aw_only_wvalid", {31'b0, dmem_wvalid}, 32'd0);
    step();
    awvalid = 1'b0;

    // Full write
    awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    dmem_wdata_read = 32'h1122_3344; awvalid = 1'b1; wvalid = 1'b1;
    sample();
    check("full_dmem_wvalid", {31'b0, dmem_wvalid}, 32'd1);
    check("full_awready", {31'b0, awready}, 32'd1);
    check("full_wready", {31'b0, wready}, 32'd1);
    check("full_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("full_bvalid_early", {31'b0, bvalid}, 32'd0);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    sample();
    check("full_bvalid", {31'b0, bvalid}, 32'd1);
    check("full_bresp", {30'b0, bresp}, 32'd0);
    check("full_no_wvalid", {31'b0, dmem_wvalid}, 32'd0);
    step();
    bready = 1'b1;
    sample();
    check("full_bvalid_hold", {31'b0, bvalid}, 32'd1);
    step();
    sample();
    check("full_bvalid_clr", {31'b0, bvalid}, 32'd0);

    // Byte strobe merge
    step();
    awaddr = 32'h10; wdata = 32'h0000_AB00; wstrb = 4'b0010;
    dmem_wdata_read = 32'h1122_3344; awvalid = 1'b1; wvalid = 1'b1;
    sample();
    check("strb_dmem_wdata", dmem_wdata, 32'h1122_AB44);
    check("strb_int_wdata", i_dmem_wdata, 32'hDEAD_ABEF);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    sample();
    check("strb_bvalid", {31'b0, bvalid}, 32'd1);
    step();
    sample();
    check("strb_bvalid_clr", {31'b0, bvalid}, 32'd0);

    // Zero strobe rewrites the old word
    step();
    wstrb = 4'h0; wdata = 32'hFFFF_FFFF; dmem_wdata_read = 32'h0BAD_F00D;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    sample();
    check("zstrb_dmem_wdata", dmem_wdata, 32'h0BAD_F00D);

    // B backpressure with a second write waiting
    step();
    awaddr = 32'h18; wdata = 32'h6666_6666; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_bvalid", {31'b0, bvalid}, 32'd1);
      check("bp_awready", {31'b0, awready}, 32'd0);
      check("bp_wready", {31'b0, wready}, 32'd0);
      check("bp_no_wvalid", {31'b0, dmem_wvalid}, 32'd0);
      step();
    end
    bready = 1'b1;
    sample();
    check("bp_release_wvalid", {31'b0, dmem_wvalid}, 32'd0);
    step();
    sample();
    check("bp_second_wvalid", {31'b0, dmem_wvalid}, 32'd1);
    check("bp_second_wdata", dmem_wdata, 32'h6666_6666);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    sample();
    check("bp_second_bvalid", {31'b0, bvalid}, 32'd1);
    step();

    // Read with R backpressure; internal instance wraps 0x20 onto word 0
    araddr = 32'h20; dmem_rdata = 32'hCAFE_CAFE; arvalid = 1'b1; rready = 1'b0;
    sample();
    check("rd_arready", {31'b0, arready}, 32'd1);
    step();
    arvalid = 1'b0; dmem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rd_rvalid", {31'b0, rvalid}, 32'd1);
      check("rd_rdata", rdata, 32'hCAFE_CAFE);
      check("rd_arready_busy", {31'b0, arready}, 32'd0);
      check("rd_rresp", {30'b0, rresp}, 32'd0);
      check("rd_int_wrap", i_rdata, 32'hDEAD_ABEF);
      step();
    end
    rready = 1'b1;
    sample();
    check("rd_rvalid_hs", {31'b0, rvalid}, 32'd1);
    step();
    sample();
    check("rd_rvalid_clr", {31'b0, rvalid}, 32'd0);
    check("rd_arready_free", {31'b0, arready}, 32'd1);

    // Same-cycle read and write on one internal word returns the old value
    step();
    awaddr = 32'h10; araddr = 32'h10; wdata = 32'h0102_0304; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    sample();
    check("rw_int_old", i_rdata, 32'hDEAD_ABEF);
    step();
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    sample();
    check("rw_int_new", i_rdata, 32'h0102_0304);
    step();

    // Signature address write: exactly one strobe with the address still on the bus
    awaddr = 32'hF000_0004; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (dmem_wvalid) begin
        pulses++;
        check("sig_awaddr", awaddr, 32'hF000_0004);
        check("sig_wdata", dmem_wdata, 32'h1234_5678);
      end
      step();
      awvalid = 1'b0; wvalid = 1'b0;
    end
    check("sig_pulses", pulses, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
